if_id_stage: RTL and testbench

- Fetch-to-decode pipeline stage for the RV32IM core: IF/ID register plus a one-entry skid buffer.
- Accepts fetched instructions over a valid/ready handshake and pre-decodes the opcode into an immediate-source select.
- Presents the packed immediate field (instr[31:7]) and the select to the immediate extender, alongside PC and register indices, for the decode stage.

---
 rtl/if_id_stage_if.sv | 49 ++++
 rtl/if_id_stage.sv | 124 ++++++++++++
 tb/tb_if_id_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
//------------------------------------------------------------------------------
// if_id_stage_if : fetch/decode handshake and decode-side bundle for if_id_stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef IMM_I
`define IMM_I 3'd0
`define IMM_S 3'd1
`define IMM_B 3'd2
`define IMM_J 3'd3
`define IMM_U 3'd4
`endif

interface if_id_stage_if #(
    parameter int XLEN = 32
);
    logic            f_valid;
    logic            f_ready;
    logic [31:0]     f_instr;
    logic [XLEN-1:0] f_pc;
    logic            flush;
    logic            d_ready;
    logic            d_valid;
    logic [31:0]     d_instr;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_pc_plus4;
    logic [24:0]     d_imm;
    logic [2:0]      d_imm_src;
    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;
    logic [4:0]      d_rd;
    logic            d_illegal;
    logic [31:0]     stall_count;

    modport master (
        output f_valid, f_instr, f_pc, flush, d_ready,
        input  f_ready, d_valid, d_instr, d_pc, d_pc_plus4, d_imm, d_imm_src,
               d_rs1, d_rs2, d_rd, d_illegal, stall_count
    );

    modport slave (
        input  f_valid, f_instr, f_pc, flush, d_ready,
        output f_ready, d_valid, d_instr, d_pc, d_pc_plus4, d_imm, d_imm_src,
               d_rs1, d_rs2, d_rd, d_illegal, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/if_id_stage.sv
//------------------------------------------------------------------------------
// if_id_stage : IF/ID register with one-entry skid buffer and immediate pre-decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef IMM_I
`define IMM_I 3'd0
`define IMM_S 3'd1
`define IMM_B 3'd2
`define IMM_J 3'd3
`define IMM_U 3'd4
`endif

module if_id_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    if_id_stage_if.slave   bus
);
    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic            r_d_valid;
    logic            r_skid_valid;
    logic            r_f_ready;
    logic [31:0]     r_d_instr;
    logic [XLEN-1:0] r_d_pc;
    logic [2:0]      r_d_imm_src;
    logic            r_d_illegal;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_stall_count;

    logic            w_xfer;
    logic            w_ld;
    logic [31:0]     w_ld_instr;
    logic [XLEN-1:0] w_ld_pc;
    logic [3:0]      w_pre;

    // Returns {illegal, imm_src}
    function automatic logic [3:0] predecode(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011: predecode = {1'b0, `IMM_I};
            7'b0100011:             predecode = {1'b0, `IMM_S};
            7'b1100011:             predecode = {1'b0, `IMM_B};
            7'b1101111:             predecode = {1'b0, `IMM_J};
            7'b0110111, 7'b0010111: predecode = {1'b0, `IMM_U};
            7'b0110011, 7'b0001111: predecode = {1'b0, `IMM_I};
            default:                predecode = {1'b1, `IMM_I};
        endcase
    endfunction

    assign w_xfer     = bus.f_valid & r_f_ready;
    assign w_ld       = ~r_d_valid | bus.d_ready;
    assign w_ld_instr = r_skid_valid ? r_skid_instr : bus.f_instr;
    assign w_ld_pc    = r_skid_valid ? r_skid_pc    : bus.f_pc;
    assign w_pre      = predecode(w_ld_instr[6:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid     <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_f_ready     <= 1'b1;
            r_d_instr     <= c_nop;
            r_d_pc        <= RESET_PC;
            r_d_imm_src   <= `IMM_I;
            r_d_illegal   <= 1'b0;
            r_skid_instr  <= c_nop;
            r_skid_pc     <= RESET_PC;
            r_stall_count <= '0;
        end else if (bus.flush) begin
            r_d_valid    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_f_ready    <= 1'b1;
        end else begin
            if (r_d_valid && !bus.d_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_ld) begin
                if (r_skid_valid || w_xfer) begin
                    r_d_instr   <= w_ld_instr;
                    r_d_pc      <= w_ld_pc;
                    r_d_imm_src <= w_pre[2:0];
                    r_d_illegal <= w_pre[3];
                end
                r_d_valid <= r_skid_valid | w_xfer;
                // Skid drains into the output; refill it if a beat arrives the same cycle
                if (r_skid_valid) begin
                    if (w_xfer) begin
                        r_skid_instr <= bus.f_instr;
                        r_skid_pc    <= bus.f_pc;
                    end else begin
                        r_skid_valid <= 1'b0;
                        r_f_ready    <= 1'b1;
                    end
                end
            end else if (w_xfer) begin
                r_skid_instr <= bus.f_instr;
                r_skid_pc    <= bus.f_pc;
                r_skid_valid <= 1'b1;
                r_f_ready    <= 1'b0;
            end
        end
    end

    assign bus.f_ready     = r_f_ready;
    assign bus.d_valid     = r_d_valid;
    assign bus.d_instr     = r_d_instr;
    assign bus.d_pc        = r_d_pc;
    assign bus.d_pc_plus4  = r_d_pc + XLEN'(4);
    assign bus.d_imm       = r_d_instr[31:7];
    assign bus.d_imm_src   = r_d_imm_src;
    assign bus.d_rs1       = r_d_instr[19:15];
    assign bus.d_rs2       = r_d_instr[24:20];
    assign bus.d_rd        = r_d_instr[11:7];
    assign bus.d_illegal   = r_d_illegal;
    assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
//------------------------------------------------------------------------------
// tb_if_id_stage : directed scoreboard bench for if_id_stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef IMM_I
`define IMM_I 3'd0
`define IMM_S 3'd1
`define IMM_B 3'd2
`define IMM_J 3'd3
`define IMM_U 3'd4
`endif

module tb_if_id_stage;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    logic  clk;
    logic  rst_n;
    beat_t sb[$];
    int    n_total;
    int    n_pass;
    int    n_fail;
    logic [31:0] exp_stall;

    if_id_stage_if #(.XLEN(32)) bus ();

    if_id_stage #(.XLEN(32), .RESET_PC(c_reset_pc)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
            7'b0110011, 7'b0001111: return {1'b0, `IMM_I};
            7'b0100011:             return {1'b0, `IMM_S};
            7'b1100011:             return {1'b0, `IMM_B};
            7'b1101111:             return {1'b0, `IMM_J};
            7'b0110111, 7'b0010111: return {1'b0, `IMM_U};
            default:                return {1'b1, `IMM_I};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Account for the coming edge using current inputs/outputs, then advance one cycle
    task automatic cycle();
        beat_t       e;
        logic [3:0]  m;
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (bus.d_valid && !bus.d_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (bus.d_valid && bus.d_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", bus.d_instr, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    m = model(e.instr[6:0]);
                    chk("d_instr",    bus.d_instr,              e.instr);
                    chk("d_pc",       bus.d_pc,                 e.pc);
                    chk("d_pc_plus4", bus.d_pc_plus4,           e.pc + 32'd4);
                    chk("d_imm",      {7'd0, bus.d_imm},        {7'd0, e.instr[31:7]});
                    chk("d_imm_src",  {29'd0, bus.d_imm_src},   {29'd0, m[2:0]});
                    chk("d_illegal",  {31'd0, bus.d_illegal},   {31'd0, m[3]});
                    chk("d_regs",     {17'd0, bus.d_rs1, bus.d_rs2, bus.d_rd},
                                      {17'd0, e.instr[19:15], e.instr[24:20], e.instr[11:7]});
                end
            end
            if (bus.f_valid && bus.f_ready) sb.push_back('{instr: bus.f_instr, pc: bus.f_pc});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] instr, input logic [31:0] pc);
        bus.f_valid = 1'b1;
        bus.f_instr = instr;
        bus.f_pc    = pc;
        cycle();
        chk("latency_d_valid", {31'd0, bus.d_valid}, 32'd1);
    endtask

    task automatic drain();
        bus.f_valid = 1'b0;
        bus.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("sb_empty", sb.size(), 32'd0);
        chk("idle_d_valid", {31'd0, bus.d_valid}, 32'd0);
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0; exp_stall = '0;
        rst_n = 1'b0;
        bus.f_valid = 1'b0; bus.f_instr = '0; bus.f_pc = '0;
        bus.flush = 1'b0;   bus.d_ready = 1'b1;
        #12;
        chk("rst_d_valid",   {31'd0, bus.d_valid},     32'd0);
        chk("rst_f_ready",   {31'd0, bus.f_ready},     32'd1);
        chk("rst_d_instr",   bus.d_instr,              32'h0000_0013);
        chk("rst_d_pc",      bus.d_pc,                 c_reset_pc);
        chk("rst_pc_plus4",  bus.d_pc_plus4,           c_reset_pc + 32'd4);
        chk("rst_imm_src",   {29'd0, bus.d_imm_src},   {29'd0, `IMM_I});
        chk("rst_illegal",   {31'd0, bus.d_illegal},   32'd0);
        chk("rst_stall",     bus.stall_count,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unstalled stream, one beat per cycle
        beat(32'h0050_0093, 32'h0000_0000);
        chk("addi_imm", {7'd0, bus.d_imm}, 32'h0000_A001);
        beat(32'h0011_2223, 32'h0000_0004);
        beat(32'h0020_8463, 32'h0000_0008);
        drain();

        // Pre-decode coverage, including illegal opcodes and PC wrap
        beat(32'h0080_00EF, 32'h0000_0100);
        beat(32'h1234_50B7, 32'h0000_0104);
        beat(32'h0000_007F, 32'h0000_0108);
        chk("illegal_7f", {31'd0, bus.d_illegal}, 32'd1);
        beat(32'h0000_0010, 32'h0000_010C);
        beat(32'h0220_80B3, 32'h0000_0110);
        chk("mul_legal", {31'd0, bus.d_illegal}, 32'd0);
        beat(32'h0000_0013, 32'hFFFF_FFFC);
        chk("pc4_wrap", bus.d_pc_plus4, 32'h0000_0000);
        drain();

        // Back-to-back beats into a three-cycle hazard stall
        chk("stall_pre", bus.stall_count, exp_stall);
        bus.d_ready = 1'b0;
        bus.f_valid = 1'b1; bus.f_instr = 32'h0010_0093; bus.f_pc = 32'h0000_0200;
        cycle();
        bus.f_instr = 32'h0020_0113; bus.f_pc = 32'h0000_0204;
        cycle();
        chk("skid_f_ready", {31'd0, bus.f_ready}, 32'd0);
        bus.f_instr = 32'h0030_0193; bus.f_pc = 32'h0000_0208;
        cycle();
        cycle();
        chk("stall_count_3", bus.stall_count, 32'd3);
        chk("stall_model",   bus.stall_count, exp_stall);
        bus.d_ready = 1'b1;
        for (int i = 0; i < 4 && !(bus.f_ready && bus.f_valid); i++) cycle();
        cycle();
        drain();

        // Flush with output and skid occupied and fetch presenting a beat
        bus.d_ready = 1'b0;
        bus.f_valid = 1'b1; bus.f_instr = 32'h0040_0213; bus.f_pc = 32'h0000_0300;
        cycle();
        bus.f_instr = 32'h0050_0293; bus.f_pc = 32'h0000_0304;
        cycle();
        bus.f_instr = 32'h0060_0313; bus.f_pc = 32'h0000_0308;
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("flush_d_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("flush_f_ready", {31'd0, bus.f_ready}, 32'd1);
        chk("flush_stall",   bus.stall_count,      exp_stall);
        drain();

        // Flush drops a beat that transfers in the same cycle
        bus.f_valid = 1'b1; bus.f_instr = 32'h0070_0393; bus.f_pc = 32'h0000_0400;
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("flush_xfer_drop", {31'd0, bus.d_valid}, 32'd0);
        drain();

        // Asynchronous reset in the middle of a stall
        bus.d_ready = 1'b0;
        bus.f_valid = 1'b1; bus.f_instr = 32'h0080_0413; bus.f_pc = 32'h0000_0500;
        cycle();
        bus.f_instr = 32'h0090_0493; bus.f_pc = 32'h0000_0504;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_d_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("arst_f_ready", {31'd0, bus.f_ready}, 32'd1);
        chk("arst_d_instr", bus.d_instr,          32'h0000_0013);
        chk("arst_stall",   bus.stall_count,      32'd0);
        sb.delete();
        exp_stall = '0;
        bus.f_valid = 1'b0;
        bus.d_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pc",    bus.d_pc,        c_reset_pc);
        chk("post_rst_stall", bus.stall_count, 32'd0);
        beat(32'h00A0_0513, 32'h0000_0600);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
